// File: rtl/prach_pkg.sv
// Shared PRACH definitions: TDM frame geometry, HB3 half-band coefficients,
// sample type and the accumulator-to-sample output conversion.
package prach_pkg;

    localparam int NumChannel     = 64;
    localparam int NumChannelUsed = 48;
    localparam int Hb3Latency     = 6;

    typedef logic signed [15:0] sample_t;

    // Unique HB3 taps in Q17: outer pair first, inner pair second.
    localparam logic signed [17:0] Hb3Coef [2] = '{-18'sd4750, 18'sd37456};

    // Scale the 36-bit accumulator by 2^-16 (floor), then clamp or wrap to 16 bits.
    function automatic sample_t hb3_acc_to_sample(input logic signed [35:0] acc,
                                                  input logic sat_en);
        logic signed [19:0] q;
        q = 20'(acc >>> 16);
        if (!sat_en) begin
            return q[15:0];
        end else if (q > 20'sd32767) begin
            return 16'sh7fff;
        end else if (q < -20'sd32768) begin
            return 16'sh8000;
        end else begin
            return q[15:0];
        end
    endfunction

endpackage

// File: rtl/delay.sv
// Generic resettable delay line: dout is din delayed by DELAY clock cycles.
module delay #(
    parameter int WIDTH = 1,
    parameter int DELAY = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] pipe_r [DELAY];

    // Shift register stages, cleared by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DELAY; i++) begin
                pipe_r[i] <= {WIDTH{1'b0}};
            end
        end else begin
            pipe_r[0] <= din;
            for (int i = 1; i < DELAY; i++) begin
                pipe_r[i] <= pipe_r[i-1];
            end
        end
    end

    assign dout = pipe_r[DELAY-1];

endmodule

// File: rtl/prach_preadd_mac.sv
// HB3 odd-phase datapath: two symmetric pre-add/multiply lanes summed into
// a registered 36-bit accumulator (data only, no reset).
module prach_preadd_mac
    import prach_pkg::*;
(
    input  logic               clk,
    input  sample_t            tap0,
    input  sample_t            tap1,
    input  sample_t            tap2,
    input  sample_t            tap3,
    output logic signed [35:0] acc
);

    logic signed [16:0] s0_s;
    logic signed [16:0] s1_s;
    logic signed [34:0] p0_s;
    logic signed [34:0] p1_s;
    logic signed [35:0] acc_r;

    // Symmetric taps share a coefficient, so pair them before multiplying.
    assign s0_s = 17'(tap0) + 17'(tap3);
    assign s1_s = 17'(tap1) + 17'(tap2);
    assign p0_s = 35'(s0_s) * 35'(Hb3Coef[0]);
    assign p1_s = 35'(s1_s) * 35'(Hb3Coef[1]);

    // Accumulator register.
    always_ff @(posedge clk) begin
        acc_r <= 36'(p0_s) + 36'(p1_s);
    end

    assign acc = acc_r;

endmodule

// File: rtl/prach_hb3_interp.sv
// PRACH HB3 half-band x2 interpolator over a 48-channel TDM stream.
// Build option: define PRACH_HB3_INTERP_SAT_EN to saturate dout_dp2 instead of wrapping.
module prach_hb3_interp
    import prach_pkg::*;
#(
    parameter int NUM_CHANNEL_USED = NumChannelUsed
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] din_dq,
    input  logic        din_dv,
    input  logic [7:0]  din_chn,
    input  logic        sync_in,
    output logic [15:0] dout_dp1,
    output logic [15:0] dout_dp2,
    output logic        dout_dv,
    output logic [7:0]  dout_chn,
    output logic        sync_out
);

    localparam int LATENCY = Hb3Latency;
    localparam int DlDepth = 3 * NUM_CHANNEL_USED + 1;
    localparam int SbWidth = 10;
`ifdef PRACH_HB3_INTERP_SAT_EN
    localparam logic SatEn = 1'b1;
`else
    localparam logic SatEn = 1'b0;
`endif

    sample_t            dline_r [DlDepth];
    sample_t            tap_r [3][4];
    sample_t            dp1_align_r;
    sample_t            dp1_out_r;
    sample_t            dp2_out_r;
    logic signed [35:0] acc_s;
    logic [LATENCY-2:0] dv_pipe_r;
    logic [SbWidth-1:0] sb_out_s;

    // Per-channel history: one slot per accepted sample, so a channel's
    // previous samples sit exactly NUM_CHANNEL_USED slots apart.
    always_ff @(posedge clk) begin
        if (din_dv) begin
            dline_r[0] <= sample_t'(din_dq);
            for (int i = 1; i < DlDepth; i++) begin
                dline_r[i] <= dline_r[i-1];
            end
        end
    end

    // Three-deep tap register pipeline, plus the even-phase alignment stage.
    always_ff @(posedge clk) begin
        for (int k = 0; k < 4; k++) begin
            tap_r[0][k] <= dline_r[k*NUM_CHANNEL_USED];
            tap_r[1][k] <= tap_r[0][k];
            tap_r[2][k] <= tap_r[1][k];
        end
        dp1_align_r <= tap_r[2][1];
    end

    prach_preadd_mac u_mac (
        .clk  (clk),
        .tap0 (tap_r[2][0]),
        .tap1 (tap_r[2][1]),
        .tap2 (tap_r[2][2]),
        .tap3 (tap_r[2][3]),
        .acc  (acc_s)
    );

    // Valid tracker that qualifies the output register one stage before dout_dv.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dv_pipe_r <= {(LATENCY-1){1'b0}};
        end else begin
            dv_pipe_r <= {dv_pipe_r[LATENCY-3:0], din_dv};
        end
    end

    // Output register: holds its value between valid samples.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dp1_out_r <= 16'sd0;
            dp2_out_r <= 16'sd0;
        end else if (dv_pipe_r[LATENCY-2]) begin
            dp1_out_r <= dp1_align_r;
            dp2_out_r <= hb3_acc_to_sample(acc_s, SatEn);
        end else begin
            dp1_out_r <= dp1_out_r;
            dp2_out_r <= dp2_out_r;
        end
    end

    delay #(
        .WIDTH (SbWidth),
        .DELAY (LATENCY)
    ) u_sideband (
        .clk   (clk),
        .rst_n (rst_n),
        .din   ({sync_in, din_dv, din_chn}),
        .dout  (sb_out_s)
    );

    assign dout_dp1 = dp1_out_r;
    assign dout_dp2 = dp2_out_r;
    assign sync_out = sb_out_s[9];
    assign dout_dv  = sb_out_s[8];
    assign dout_chn = sb_out_s[7:0];

endmodule
